// File: rtl/fila_pkg.sv
// Shared definitions for the 8-entry byte queue and its consumer-side reader.
package fila_pkg;

    localparam int FILA_DEPTH = 8;
    localparam int DATA_W     = 8;
    localparam int LEN_W      = 8;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT_DATA,
        SETTLE,
        PRESENT
    } leitor_state_t;

endpackage

// File: rtl/leitor_fila_if.sv
// Queue-side and stream-side signals of the queue reader; master = the reader.
interface leitor_fila_if;
    import fila_pkg::*;

    logic              enable;
    logic [LEN_W-1:0]  len_in;
    logic [DATA_W-1:0] data_in;
    logic              dequeue_out;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              busy;
    logic [7:0]        read_count;
    logic              timeout_err;

    modport master (
        input  enable, len_in, data_in, out_ready,
        output dequeue_out, out_data, out_valid, busy, read_count, timeout_err
    );

    modport slave (
        output enable, len_in, data_in, out_ready,
        input  dequeue_out, out_data, out_valid, busy, read_count, timeout_err
    );

endinterface

// File: rtl/leitor_fila.sv
// Queue reader: issues one dequeue per byte, captures it and presents it on valid/ready.
// Optional downstream stall timeout enabled by defining LEITOR_FILA_TIMEOUT_EN.
module leitor_fila
    import fila_pkg::*;
#(
    parameter int SETTLE_CYCLES  = 1,
    parameter int TIMEOUT_CYCLES = 200
) (
    input  logic          clk_10KHz,
    input  logic          reset,
    leitor_fila_if.master bus
);

    localparam logic [2:0] SETTLE_LOAD = 3'(SETTLE_CYCLES - 1);

    leitor_state_t     state, state_nxt;
    logic              deq_q;
    logic [DATA_W-1:0] data_q;
    logic              valid_q;
    logic [7:0]        rc_q;
    logic [2:0]        settle_cnt;
    logic              accept;
    logic              timeout_hit;

    assign accept = (state == PRESENT) && valid_q && bus.out_ready;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (bus.enable && (bus.len_in != '0)) state_nxt = REQ;
            REQ:       state_nxt = WAIT_DATA;
            WAIT_DATA: state_nxt = SETTLE;
            SETTLE:    if (settle_cnt == '0) state_nxt = PRESENT;
            PRESENT:   if (accept || timeout_hit) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    // dequeue_out and out_valid are registered copies of the state being entered
    always_ff @(posedge clk_10KHz or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            deq_q      <= 1'b0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            rc_q       <= '0;
            settle_cnt <= '0;
        end else begin
            state   <= state_nxt;
            deq_q   <= (state_nxt == REQ);
            valid_q <= (state_nxt == PRESENT);
            if (state == WAIT_DATA) begin
                data_q     <= bus.data_in;
                settle_cnt <= SETTLE_LOAD;
            end else if ((state == SETTLE) && (settle_cnt != '0)) begin
                settle_cnt <= settle_cnt - 3'd1;
            end
            if (accept) rc_q <= rc_q + 8'd1;
        end
    end

`ifdef LEITOR_FILA_TIMEOUT_EN
    localparam logic [15:0] STALL_LIMIT = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] stall_cnt;
    logic        err_q;

    assign timeout_hit = (state == PRESENT) && !bus.out_ready && (stall_cnt == STALL_LIMIT);

    // Held at zero outside PRESENT, so every presented byte starts a fresh count
    always_ff @(posedge clk_10KHz or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
            err_q     <= 1'b0;
        end else begin
            if (state != PRESENT) stall_cnt <= '0;
            else if (!bus.out_ready) stall_cnt <= stall_cnt + 16'd1;
            if (timeout_hit) err_q <= 1'b1;
        end
    end

    assign bus.timeout_err = err_q;
`else
    // No stall limit in this build; the comparison is false for any legal limit
    assign timeout_hit     = (TIMEOUT_CYCLES < 0);
    assign bus.timeout_err = 1'b0;
`endif

    assign bus.dequeue_out = deq_q;
    assign bus.out_data    = data_q;
    assign bus.out_valid   = valid_q;
    assign bus.busy        = (state != IDLE);
    assign bus.read_count  = rc_q;

endmodule

// File: tb/tb_leitor_fila.sv
// Scoreboard bench for leitor_fila with a behavioural model of the byte queue.
module tb_leitor_fila;
    import fila_pkg::*;

`ifdef LEITOR_FILA_TIMEOUT_EN
    localparam int TO     = 10;
    localparam int STALL3 = 6;
`else
    localparam int TO     = 200;
    localparam int STALL3 = 20;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    leitor_fila_if bus();

    leitor_fila #(.SETTLE_CYCLES(1), .TIMEOUT_CYCLES(TO)) dut (
        .clk_10KHz (clk),
        .reset     (reset),
        .bus       (bus)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [7:0] q_mem[$];
    logic [7:0] exp_q[$];
    int         exp_rc;
    int         deq_cnt = 0;
    logic       pend;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Queue model: samples dequeue at E1 (drives head), shifts at E2, len visible from E3
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            q_mem.delete();
            pend = 1'b0;
            bus.len_in  <= '0;
            bus.data_in <= '0;
        end else begin
            bus.len_in <= 8'(q_mem.size());
            if (pend && q_mem.size() > 0) void'(q_mem.pop_front());
            pend = bus.dequeue_out;
            if (bus.dequeue_out && q_mem.size() > 0) bus.data_in <= q_mem[0];
        end
    end

    // Monitor: pops the scoreboard whenever the DUT hands over (or drops) a byte
    logic       deq_prev, prev_valid, prev_acc;
    logic [7:0] held;
    int         vcnt, last_deq, last_acc;

    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
            exp_rc     = 0;
            deq_prev   = 1'b0;
            prev_valid = 1'b0;
            prev_acc   = 1'b0;
            vcnt       = 0;
            last_deq   = -100;
            last_acc   = -100;
        end else begin
            if (bus.dequeue_out) begin
                deq_cnt++;
                chk("deq_pulse", {29'd0, deq_prev, (cyc - last_deq) >= 4, q_mem.size() > 0}, 32'b011);
                last_deq = cyc;
            end
            deq_prev = bus.dequeue_out;
            if (prev_valid && !prev_acc && bus.out_valid)
                chk("hold_data", bus.out_data, held);
            if (prev_valid && !prev_acc && !bus.out_valid) begin
`ifdef LEITOR_FILA_TIMEOUT_EN
                chk("timeout_len", vcnt, TO);
                chk("timeout_err", bus.timeout_err, 1);
                chk("timeout_rc", bus.read_count, 8'(exp_rc));
                if (exp_q.size() > 0) void'(exp_q.pop_front());
`else
                chk("valid_drop", bus.out_valid, 1);
`endif
            end
            if (bus.out_valid) chk("busy_valid", bus.busy, 1);
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("extra_byte", exp_q.size(), 1);
                end else begin
                    chk("byte", bus.out_data, exp_q[0]);
                    chk("read_count", bus.read_count, 8'(exp_rc));
                    chk("byte_gap", (cyc - last_acc) >= 4, 1);
                    void'(exp_q.pop_front());
                    exp_rc++;
                    last_acc = cyc;
                end
            end
            vcnt       = bus.out_valid ? vcnt + 1 : 0;
            held       = bus.out_data;
            prev_valid = bus.out_valid;
            prev_acc   = bus.out_valid && bus.out_ready;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        q_mem.push_back(b);
        exp_q.push_back(b);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (!(exp_q.size() == 0 && q_mem.size() == 0 && !bus.busy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("drain_budget", n < budget, 1);
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_deq(input int budget);
        int n = 0;
        @(negedge clk);
        while (!bus.dequeue_out && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("deq_seen", bus.dequeue_out, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "global timeout");
    end

    initial begin
        int d0;
        int n;
        int rc0;
        reset         = 1'b1;
        bus.enable    = 1'b0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_dequeue", bus.dequeue_out, 0);
        chk("rst_data",    bus.out_data, 0);
        chk("rst_valid",   bus.out_valid, 0);
        chk("rst_busy",    bus.busy, 0);
        chk("rst_rc",      bus.read_count, 0);
        chk("rst_err",     bus.timeout_err, 0);
        reset = 1'b0;

        // Three preloaded bytes drained in order
        step();
        push(8'h11); push(8'h22); push(8'h33);
        d0 = deq_cnt;
        step();
        bus.enable    = 1'b1;
        bus.out_ready = 1'b1;
        wait_idle(100);
        chk("t1_deq_count", deq_cnt - d0, 3);
        chk("t1_rc",        bus.read_count, 3);
        chk("t1_busy",      bus.busy, 0);
        chk("t1_len",       bus.len_in, 0);

        // Empty queue: never dequeue
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            chk("t2_idle", {bus.dequeue_out, bus.busy}, 0);
        end

        // Long stall then accept on first ready edge
        step();
        bus.out_ready = 1'b0;
        push(8'hA5);
        n = 0;
        @(negedge clk);
        while (!bus.out_valid && n < 20) begin @(negedge clk); n++; end
        for (int i = 0; i < STALL3; i++) begin
            chk("t3_stall", {bus.out_valid, bus.out_data}, {1'b1, 8'hA5});
            @(negedge clk);
        end
        step();
        bus.out_ready = 1'b1;
        step();
        chk("t3_accepted", bus.out_valid, 0);
        chk("t3_rc", bus.read_count, 4);

        // Reset while waiting for queue data
        push(8'h5A); push(8'hC3);
        wait_deq(20);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("t4_async", {bus.dequeue_out, bus.out_data, bus.out_valid, bus.busy, bus.read_count},
            0);
        repeat (2) @(negedge clk);
        step();
        reset = 1'b0;
        step();
        push(8'h3D); push(8'hE7);
        wait_idle(100);
        chk("t4_rc", bus.read_count, 2);

        // enable dropped the cycle after REQ
        push(8'h81); push(8'h92);
        wait_deq(20);
        step();
        bus.enable = 1'b0;
        d0 = deq_cnt;
        repeat (20) @(negedge clk);
        chk("t5_no_deq", deq_cnt - d0, 0);
        chk("t5_len",    bus.len_in, 1);
        chk("t5_left",   exp_q.size(), 1);
        chk("t5_rc",     bus.read_count, 3);
        step();
        bus.enable = 1'b1;
        wait_idle(100);

        // Randomized bursts with random back-pressure and enable
        for (int r = 0; r < 8; r++) begin
            step();
            n = $urandom_range(1, 5);
            for (int k = 0; k < n; k++)
                if (q_mem.size() < FILA_DEPTH) push(8'($urandom));
            for (int c = 0; c < 60; c++) begin
                step();
                bus.out_ready = ($urandom_range(0, 3) != 0);
                bus.enable    = ($urandom_range(0, 4) != 0);
            end
            bus.enable    = 1'b1;
            bus.out_ready = 1'b1;
            wait_idle(200);
            chk("rand_rc", bus.read_count, 8'(exp_rc));
        end

`ifdef LEITOR_FILA_TIMEOUT_EN
        // Stall past the limit: first byte dropped, next one delivered
        step();
        bus.out_ready = 1'b0;
        rc0 = exp_rc;
        push(8'h3C); push(8'h7E);
        n = 0;
        while (!bus.timeout_err && n < 60) begin @(negedge clk); n++; end
        chk("t6_err_seen", bus.timeout_err, 1);
        step();
        bus.out_ready = 1'b1;
        wait_idle(100);
        chk("t6_rc",  bus.read_count, 8'(rc0 + 1));
        chk("t6_err", bus.timeout_err, 1);
`else
        rc0 = exp_rc;
        chk("no_timeout_err", bus.timeout_err, 0);
        chk("final_rc", bus.read_count, 8'(rc0));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/leitor_fila.md
Name: leitor_fila

Overview:
- Consumer-side controller for the 8-entry byte queue.
- Watches the queue's registered length, issues single-cycle dequeue pulses, and captures the dequeued byte.
- Presents each byte downstream on a valid/ready handshake.
- Sits between the queue and any byte sink (display driver, serial transmitter); turns the queue's multi-cycle dequeue protocol into a clean stream.

Parameters:
- SETTLE_CYCLES, 1: extra cycles waited after capture so the queue's length output reflects the completed dequeue; legal range 1..7.
- TIMEOUT_CYCLES, 200: downstream stall limit in cycles; used only with the optional feature.

Ports:
- clk_10KHz  input  1  system clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-high reset.
- enable  input  1  1 = drain the queue; 0 = no new dequeue starts.
- len_in  input  8  queue occupancy; registered by the queue, lags its internal count by one cycle.
- data_in  input  8  queue head byte; valid from the edge after dequeue is sampled.
- dequeue_out  output  1  dequeue request to the queue; registered; one-cycle pulse.
- out_data  output  8  captured byte.
- out_valid  output  1  out_data valid.
- out_ready  input  1  downstream accepts out_data when out_valid && out_ready at a rising edge.
- busy  output  1  high in every state except IDLE.
- read_count  output  8  bytes delivered since reset; wraps 255->0.
- timeout_err  output  1  sticky stall error; exists only with the optional feature, otherwise tied 0.

Behaviour:
- Reset (async, immediate), all outputs 0:
  - state=IDLE; dequeue_out=0; out_data=0; out_valid=0; busy=0; read_count=0; timeout_err=0; settle counter=0.
- Queue protocol the block obeys:
  - Queue samples dequeue at edge E1 and drives data_in from E1.
  - Queue shifts at E2; len_in shows the new count from E3.
  - A second dequeue pulse before E3 is forbidden.
- FSM states and transitions:
  - IDLE: if enable && len_in!=0, go to REQ. Otherwise stay.
  - REQ: dequeue_out=1 for exactly this cycle; go to WAIT_DATA unconditionally.
  - WAIT_DATA: on exit edge, out_data<=data_in; load settle counter with SETTLE_CYCLES-1; go to SETTLE.
  - SETTLE: count down to 0 while holding out_data; at 0, go to PRESENT.
  - PRESENT: out_valid=1, out_data stable. On out_valid && out_ready: out_valid<=0, read_count<=read_count+1 (8-bit wrap), go to IDLE.
- Latency:
  - out_valid rises 3 cycles after the IDLE->REQ edge (SETTLE_CYCLES=1).
  - Minimum byte period with out_ready held high: 4 cycles.
- Boundary conditions:
  - enable dropped mid-transaction: the current byte completes through PRESENT. enable is checked only in IDLE.
  - len_in=0 in IDLE: no dequeue is issued, ever.
  - len_in is never sampled outside IDLE; by construction IDLE is re-entered at or after E3.
  - out_ready high while out_valid=0: ignored.
  - out_ready held low: stays in PRESENT indefinitely (unless the optional feature is enabled).
  - Reset mid-transaction: immediate return to IDLE with outputs cleared. An in-flight dequeue is not replayed; queue reset is expected alongside.

Optional Feature:
- Macro: LEITOR_FILA_TIMEOUT_EN.
- Defined:
  - A 16-bit stall counter runs in PRESENT while out_ready=0.
  - On reaching TIMEOUT_CYCLES: byte dropped, out_valid<=0, timeout_err<=1 (sticky until reset), read_count unchanged, go to IDLE.
  - The counter clears on entry to PRESENT.
- Undefined: no stall counter; PRESENT waits forever; timeout_err is constant 0.

Decomposition:
- Shared package fila_pkg:
  - FILA_DEPTH=8; DATA_W=8; LEN_W=8.
  - Enum leitor_state_t {IDLE, REQ, WAIT_DATA, SETTLE, PRESENT}.
- No sub-module; a single FSM with counters is the natural size.
- Integration bench instantiates leitor_fila with the existing queue.

Test Plan:
1. Queue preloaded 0x11,0x22,0x33; enable=1; out_ready=1 -> out_data 0x11,0x22,0x33 in order, 4 cycles apart; exactly 3 dequeue pulses each 1 cycle wide; read_count=3; busy=0 once len_in=0.
2. len_in=0, enable=1 for 50 cycles -> dequeue_out never asserts, busy=0.
3. One byte 0xA5; out_ready=0 for 20 cycles, then 1 -> out_valid and out_data=0xA5 stable throughout; accepted on the first ready edge; read_count=1.
4. Reset asserted in WAIT_DATA -> all outputs 0 asynchronously; after release with len_in=2, normal draining resumes.
5. enable deasserted the cycle after REQ, queue holds 2 bytes -> first byte delivered; second never requested; len_in stays 1.
6. LEITOR_FILA_TIMEOUT_EN defined, TIMEOUT_CYCLES=10, out_ready=0 -> out_valid falls after 10 cycles; timeout_err=1; read_count=0; next byte still drained.
